pingpong_weight_buffer: RTL and testbench

- Parametrised double-buffered (ping-pong) weight store for the systolic array.
- The host/DMA fills one bank while the other bank streams weight rows to the PE array.
- The streaming side replays a bank RPT times for weight reuse across input tiles, then releases it.
- Generalises the single-bank 128-bit weight buffer: adds parametrised width/depth, two banks, length/repeat sequencing and valid/last framing.

---
 rtl/pingpong_weight_buffer.sv | 156 +++++++++++++++
 tb/tb_pingpong_weight_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_weight_buffer.sv
// Two-bank weight store: host fills one bank while the other streams rows (one per cycle,
// replayed rpt times) to the PE array; bank ownership is handed over through full[] flags.
module pingpong_weight_buffer #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int RPT_W  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WEN,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] D,
  input  logic              W_COMMIT,
  input  logic [ADDR_W:0]   W_LEN,
  output logic              W_FULL,
  input  logic              START,
  input  logic [RPT_W-1:0]  RPT,
  output logic              R_AVAIL,
  output logic              BUSY,
  output logic [DATA_W-1:0] Q,
  output logic              Q_VALID,
  output logic              Q_LAST
);

  localparam int AIDX = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_t;

  state_t            state_q;
  logic [1:0]        full_q, full_d;
  logic [ADDR_W:0]   len_q [2];
  logic [ADDR_W:0]   len_d [2];
  logic              fill_sel_q, fill_sel_d;
  logic              drain_sel_q, drain_sel_d;
  logic [ADDR_W-1:0] row_q;
  logic [RPT_W-1:0]  pass_q;
  logic [RPT_W-1:0]  rpt_q;
  logic [DATA_W-1:0] q_q;
  logic              q_valid_q;
  logic              q_last_q;

  logic [DATA_W-1:0] mem_q [2][DEPTH];

  logic            wa_ok, len_ok, wr_en, cmt_en, start_en;
  logic            end_row, end_pass, release_en;
  logic [AIDX-1:0] wa_idx, rd_idx;

  assign W_FULL  = full_q[fill_sel_q];
  assign R_AVAIL = (state_q == S_IDLE) && full_q[drain_sel_q];
  assign BUSY    = (state_q == S_STREAM);
  assign Q       = q_q;
  assign Q_VALID = q_valid_q;
  assign Q_LAST  = q_last_q;

  // Indices are truncated to the memory depth; the range checks guarantee no aliasing.
  assign wa_idx = WA[AIDX-1:0];
  assign rd_idx = row_q[AIDX-1:0];

  assign wa_ok    = ({1'b0, WA} < DEPTH_L);
  assign len_ok   = (W_LEN != '0) && (W_LEN <= DEPTH_L);
  assign wr_en    = !RST && !WEN && !W_FULL && wa_ok;
  assign cmt_en   = W_COMMIT && !W_FULL && len_ok;
  assign start_en = START && R_AVAIL;

  assign end_row    = (({1'b0, row_q} + (ADDR_W+1)'(1)) == len_q[drain_sel_q]);
  assign end_pass   = (pass_q == (rpt_q - RPT_W'(1)));
  assign release_en = (state_q == S_STREAM) && end_row && end_pass;

  // Commit and release always address different banks, so both may apply on one edge.
  always_comb begin
    full_d      = full_q;
    len_d       = len_q;
    fill_sel_d  = fill_sel_q;
    drain_sel_d = drain_sel_q;
    if (cmt_en) begin
      full_d[fill_sel_q] = 1'b1;
      len_d[fill_sel_q]  = W_LEN;
      fill_sel_d         = ~fill_sel_q;
    end
    if (release_en) begin
      full_d[drain_sel_q] = 1'b0;
      drain_sel_d         = ~drain_sel_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      full_q      <= '0;
      len_q[0]    <= '0;
      len_q[1]    <= '0;
      fill_sel_q  <= 1'b0;
      drain_sel_q <= 1'b0;
    end else begin
      full_q      <= full_d;
      len_q       <= len_d;
      fill_sel_q  <= fill_sel_d;
      drain_sel_q <= drain_sel_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[fill_sel_q][wa_idx] <= D;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      pass_q    <= '0;
      rpt_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      q_last_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          q_q       <= '0;
          q_valid_q <= 1'b0;
          q_last_q  <= 1'b0;
          if (start_en) begin
            rpt_q   <= (RPT == '0) ? RPT_W'(1) : RPT;
            row_q   <= '0;
            pass_q  <= '0;
            state_q <= S_STREAM;
          end
        end
        S_STREAM: begin
          q_q       <= mem_q[drain_sel_q][rd_idx];
          q_valid_q <= 1'b1;
          q_last_q  <= end_row && end_pass;
          if (end_row) begin
            row_q <= '0;
            if (end_pass) begin
              pass_q  <= '0;
              state_q <= S_IDLE;
            end else begin
              pass_q <= pass_q + RPT_W'(1);
            end
          end else begin
            row_q <= row_q + ADDR_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pingpong_weight_buffer.sv
// Directed plus random bench; expected outputs come from a transaction-level model of both banks.
module tb_pingpong_weight_buffer;

  localparam int DW  = 128;
  localparam int DEP = 16;
  localparam int AW  = 5;
  localparam int RW  = 4;

  logic          CLK = 1'b0;
  logic          RST, WEN, W_COMMIT, START;
  logic [AW-1:0] WA;
  logic [DW-1:0] D;
  logic [AW:0]   W_LEN;
  logic [RW-1:0] RPT;
  logic          W_FULL, R_AVAIL, BUSY, Q_VALID, Q_LAST;
  logic [DW-1:0] Q;

  pingpong_weight_buffer #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .RPT_W(RW)) dut (
    .CLK(CLK), .RST(RST), .WEN(WEN), .WA(WA), .D(D),
    .W_COMMIT(W_COMMIT), .W_LEN(W_LEN), .W_FULL(W_FULL),
    .START(START), .RPT(RPT), .R_AVAIL(R_AVAIL), .BUSY(BUSY),
    .Q(Q), .Q_VALID(Q_VALID), .Q_LAST(Q_LAST)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0] d;
    bit            last;
  } beat_t;

  logic [DW-1:0] mem_m [2][DEP];
  bit            full_m [2];
  int            len_m [2];
  bit            fill_m, drain_m;
  beat_t         pend [$];
  logic [DW-1:0] eq;
  bit            ev, el;

  int n_chk = 0;
  int n_fail = 0;
  int vcnt = 0;
  int lcnt = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The stream is modelled as a queue of beats built when START is accepted.
  task automatic model_edge();
    bit    wf, ra, busy, f, dr;
    int    r;
    beat_t b;
    if (RST) begin
      full_m = '{0, 0};
      len_m  = '{0, 0};
      fill_m = 0;
      drain_m = 0;
      pend.delete();
      eq = '0; ev = 0; el = 0;
      return;
    end
    wf   = full_m[fill_m];
    busy = (pend.size() != 0);
    ra   = !busy && full_m[drain_m];
    f    = fill_m;
    dr   = drain_m;
    if (!WEN && !wf && WA < DEP) mem_m[f][WA] = D;
    if (W_COMMIT && !wf && W_LEN >= 1 && W_LEN <= DEP) begin
      full_m[f] = 1;
      len_m[f]  = int'(W_LEN);
      fill_m    = !f;
    end
    if (busy) begin
      b  = pend.pop_front();
      eq = b.d; ev = 1; el = b.last;
      if (pend.size() == 0) begin
        full_m[dr] = 0;
        drain_m    = !dr;
      end
    end else begin
      eq = '0; ev = 0; el = 0;
      if (START && ra) begin
        r = (RPT == 0) ? 1 : int'(RPT);
        for (int p = 0; p < r; p++)
          for (int i = 0; i < len_m[dr]; i++)
            pend.push_back('{mem_m[dr][i], (p == r-1) && (i == len_m[dr]-1)});
      end
    end
  endtask

  task automatic idle_in();
    RST = 0; WEN = 1; W_COMMIT = 0; START = 0;
  endtask

  task automatic step();
    model_edge();
    @(posedge CLK);
    #1;
    chk("Q", Q, eq);
    chk("Q_VALID", DW'(Q_VALID), DW'(ev));
    chk("Q_LAST", DW'(Q_LAST), DW'(el));
    chk("BUSY", DW'(BUSY), DW'(pend.size() != 0));
    chk("W_FULL", DW'(W_FULL), DW'(full_m[fill_m]));
    chk("R_AVAIL", DW'(R_AVAIL), DW'((pend.size() == 0) && full_m[drain_m]));
    if (Q_VALID === 1'b1) vcnt++;
    if (Q_LAST === 1'b1) lcnt++;
    idle_in();
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wr(input int a, input logic [DW-1:0] d);
    WEN = 0; WA = AW'(a); D = d; step();
  endtask

  task automatic cmt(input int l);
    W_COMMIT = 1; W_LEN = (AW+1)'(l); step();
  endtask

  task automatic st(input int r);
    START = 1; RPT = RW'(r); step();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] a_d, b_d;
    for (int b = 0; b < 2; b++) for (int i = 0; i < DEP; i++) mem_m[b][i] = '0;
    idle_in();
    WA = '0; D = '0; W_LEN = '0; RPT = '0;
    RST = 1; step();
    RST = 1; step();
    chk("reset Q", Q, '0);
    chk("reset BUSY", DW'(BUSY), '0);

    // Define every row of both banks so later streams never read uninitialised storage.
    for (int i = 0; i < DEP; i++) wr(i, rnd());
    cmt(DEP);
    for (int i = 0; i < DEP; i++) wr(i, rnd());
    cmt(DEP);
    st(1); run(DEP + 1);
    st(1); run(DEP + 1);

    // Four rows 1..4, single pass.
    for (int i = 0; i < 4; i++) wr(i, DW'(i + 1));
    cmt(4);
    vcnt = 0; lcnt = 0;
    st(1); run(6);
    chk("t1 beats", DW'(vcnt), DW'(4));
    chk("t1 lasts", DW'(lcnt), DW'(1));

    // Two rows replayed three times, then RPT=0 behaves as one pass.
    a_d = rnd(); b_d = rnd();
    wr(0, a_d); wr(1, b_d); cmt(2);
    vcnt = 0; lcnt = 0;
    st(3); run(8);
    chk("t2 rpt3 beats", DW'(vcnt), DW'(6));
    chk("t2 rpt3 lasts", DW'(lcnt), DW'(1));
    wr(0, a_d); wr(1, b_d); cmt(2);
    vcnt = 0;
    st(0); run(4);
    chk("t2 rpt0 beats", DW'(vcnt), DW'(2));

    // Stream one full bank while filling the other; a third fill is refused.
    for (int i = 0; i < DEP; i++) wr(i, rnd());
    cmt(DEP);
    st(2);
    for (int i = 0; i < DEP; i++) wr(i, rnd());
    cmt(DEP);
    chk("t3 W_FULL", DW'(W_FULL), DW'(1));
    wr(0, rnd()); cmt(5);
    run(20);
    vcnt = 0;
    st(1); run(DEP + 2);
    chk("t3 bank1 beats", DW'(vcnt), DW'(DEP));

    // Illegal commits, out-of-range writes and START with nothing full.
    cmt(0); cmt(DEP + 1);
    chk("t4 W_FULL", DW'(W_FULL), DW'(0));
    wr(16, rnd()); wr(19, rnd());
    vcnt = 0;
    st(1); run(3);
    chk("t4 no beats", DW'(vcnt), DW'(0));

    // Reset in the middle of an eight-row stream.
    for (int i = 0; i < 8; i++) wr(i, rnd());
    cmt(8);
    st(1); run(2);
    RST = 1; step();
    chk("t5 Q_VALID", DW'(Q_VALID), DW'(0));
    chk("t5 R_AVAIL", DW'(R_AVAIL), DW'(0));
    for (int i = 0; i < 8; i++) wr(i, rnd());
    cmt(8);
    vcnt = 0;
    st(1); run(10);
    chk("t5 refill beats", DW'(vcnt), DW'(8));

    // Commit on the same edge as the final beat of the other bank.
    for (int i = 0; i < 3; i++) wr(i, rnd());
    cmt(3);
    wr(0, rnd()); wr(1, rnd());
    st(1); run(2);
    cmt(2);
    chk("t6 last", DW'(Q_LAST), DW'(1));
    chk("t6 R_AVAIL", DW'(R_AVAIL), DW'(1));
    st(1); run(3);

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      RST      = ($urandom_range(0, 99) == 0);
      WEN      = $urandom_range(0, 1) != 0;
      WA       = AW'($urandom_range(0, 19));
      D        = rnd();
      W_COMMIT = ($urandom_range(0, 7) == 0);
      W_LEN    = (AW+1)'($urandom_range(0, 18));
      START    = ($urandom_range(0, 3) == 0);
      RPT      = RW'($urandom_range(0, 3));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
